// File: rtl/my_design_pkg.sv
// Shared defaults and sizing helpers for the my_design input conditioner.
package my_design_pkg;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 3;

  // Counter must hold values 0 .. STABLE_CYCLES-1 without wrapping.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/my_design_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else       sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/my_design.sv
// Input conditioner: synchronises 'in', then passes a new level to 'out' only
// after it has persisted for STABLE_CYCLES consecutive clk edges.
module my_design
  import my_design_pkg::*;
#(
  parameter int   SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int   STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("my_design: STABLE_CYCLES must be >= 1");
  end

  localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (s)
  );

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (s != out_q) begin
      if (cnt_q == CNT_LAST) out_d = s;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_my_design.sv
// Directed bench for my_design at default parameters (2 sync stages, 3 stable edges).
module tb_my_design;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic in_i  = 1'b0;
  logic out_o;

  int tests  = 0;
  int failed = 0;

  time last_pos   = 0;
  bit  seen_reset = 1'b0;

  my_design dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_i),
    .out   (out_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_pos = $time;
  always @(posedge reset) seen_reset = 1'b1;

  // Out may only move on a rising clk edge, or asynchronously while reset is high.
  always @(out_o) begin
    if (seen_reset) begin
      tests++;
      if (!reset && $time != last_pos) begin
        failed++;
        $display("FAIL out_edge: out changed to %b at t=%0t, not on a posedge (last posedge t=%0t)",
                 out_o, $time, last_pos);
      end
    end
  end

  always @(negedge clk) begin
    if (seen_reset && !reset) begin
      tests++;
      if ($isunknown(out_o)) begin
        failed++;
        $display("FAIL out_known: out=%b at t=%0t, required 0 or 1", out_o, $time);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_i  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Spec vector 1: reset 1 at t=10, 0 at t=20.
  task automatic test_reset();
    #10 reset = 1'b1;
    #2;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL reset_async: out=%b at t=%0t, required 0", out_o, $time);
    end
    #6;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL reset_held: out=%b at t=%0t, required 0", out_o, $time);
    end
    #2 reset = 1'b0;
    #0;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL reset_release: out=%b at t=%0t, required 0", out_o, $time);
    end
  endtask

  // Spec vector 2: in 0->1 at t=20 held; out rises at posedge t=65.
  task automatic test_rise();
    in_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #10;
      tests++;
      if (out_o !== 1'b0) begin
        failed++; $display("FAIL rise_wait: out=%b at t=%0t, required 0", out_o, $time);
      end
    end
    #4;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL rise_early: out=%b at t=%0t, required 0", out_o, $time);
    end
    #2;
    tests++;
    if (out_o !== 1'b1) begin
      failed++; $display("FAIL rise_edge: out=%b at t=%0t, required 1", out_o, $time);
    end
  endtask

  // 3-edge pulse passes: rises T+45, falls T+75.
  task automatic test_pulse_pass();
    time t0;
    apply_reset();
    t0 = $time;
    in_i = 1'b1;
    #30 in_i = 1'b0;
    #14;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL pulse_pre: out=%b at t=%0t (T+%0t), required 0", out_o, $time, $time - t0);
    end
    #2;
    tests++;
    if (out_o !== 1'b1) begin
      failed++; $display("FAIL pulse_rise: out=%b at t=%0t (T+%0t), required 1", out_o, $time, $time - t0);
    end
    #28;
    tests++;
    if (out_o !== 1'b1) begin
      failed++; $display("FAIL pulse_hold: out=%b at t=%0t (T+%0t), required 1", out_o, $time, $time - t0);
    end
    #2;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL pulse_fall: out=%b at t=%0t (T+%0t), required 0", out_o, $time, $time - t0);
    end
  endtask

  // 2-edge pulse is filtered.
  task automatic test_short_pulse();
    apply_reset();
    in_i = 1'b1;
    #20 in_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #10;
      tests++;
      if (out_o !== 1'b0) begin
        failed++; $display("FAIL short_pulse: out=%b at t=%0t, required 0", out_o, $time);
      end
    end
  endtask

  // Two 2-edge pulses separated by one low edge: counter must restart.
  task automatic test_back_to_back();
    apply_reset();
    in_i = 1'b1;
    #20 in_i = 1'b0;
    #10 in_i = 1'b1;
    #20 in_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #10;
      tests++;
      if (out_o !== 1'b0) begin
        failed++; $display("FAIL back_to_back: out=%b at t=%0t, required 0", out_o, $time);
      end
    end
  endtask

  // Out high, 2-edge low glitch is filtered the same way.
  task automatic test_glitch_low();
    apply_reset();
    in_i = 1'b1;
    #50;
    tests++;
    if (out_o !== 1'b1) begin
      failed++; $display("FAIL glitch_setup: out=%b at t=%0t, required 1", out_o, $time);
    end
    in_i = 1'b0;
    #20 in_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #10;
      tests++;
      if (out_o !== 1'b1) begin
        failed++; $display("FAIL glitch_low: out=%b at t=%0t, required 1", out_o, $time);
      end
    end
  endtask

  // Spec vector 5: in held 1, out 1, reset pulsed mid-cycle.
  task automatic test_reset_async();
    time t0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL rst_async: out=%b at t=%0t, required 0", out_o, $time);
    end
    @(negedge clk);
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL rst_hold: out=%b at t=%0t, required 0", out_o, $time);
    end
    reset = 1'b0;
    t0 = $time;
    #44;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL rst_rerise_pre: out=%b at T+%0t, required 0", out_o, $time - t0);
    end
    #2;
    tests++;
    if (out_o !== 1'b1) begin
      failed++; $display("FAIL rst_rerise: out=%b at T+%0t, required 1", out_o, $time - t0);
    end
  endtask

  // Reset during a pending count must clear it: full latency after release.
  task automatic test_reset_mid_count();
    time t0;
    apply_reset();
    in_i = 1'b1;
    #38 reset = 1'b1;
    #1;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL midcnt_rst: out=%b at t=%0t, required 0", out_o, $time);
    end
    #1 reset = 1'b0;
    t0 = $time;
    #44;
    tests++;
    if (out_o !== 1'b0) begin
      failed++; $display("FAIL midcnt_pre: out=%b at T+%0t, required 0", out_o, $time - t0);
    end
    #2;
    tests++;
    if (out_o !== 1'b1) begin
      failed++; $display("FAIL midcnt_rise: out=%b at T+%0t, required 1", out_o, $time - t0);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_pulse_pass();
    test_short_pulse();
    test_back_to_back();
    test_glitch_low();
    test_reset_async();
    test_reset_mid_count();
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
